// File: rtl/accum_scheduler_pkg.sv
// Shared correlator definitions: default geometry of the accumulate schedule
// and the scheduler state encoding.
package accum_scheduler_pkg;

   localparam int TRATE_DEFAULT = 30;
   localparam int TBITS_DEFAULT = 5;
   localparam int LOOPS_DEFAULT = 8;
   localparam int LBITS_DEFAULT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } sched_state_t;

endpackage

// File: rtl/accum_scheduler_if.sv
// Control bundle between the accumulate scheduler and the correlator/accumulator
// datapath. The master drives the requests; the scheduler is the slave.
interface accum_scheduler_if
   import accum_scheduler_pkg::*;
#(
   parameter int TBITS = TBITS_DEFAULT,
   parameter int LBITS = LBITS_DEFAULT
) ();

   logic             start_i;
   logic             stop_i;
   logic             sums_valid_i;
   logic             pass_i;
   logic             frame_ready_i;

   logic             enable_o;
   logic [TBITS-1:0] tsel_o;
   logic             clear_o;
   logic             frame_o;
   logic [LBITS-1:0] pass_o;
   logic             busy_o;
   logic             overrun_o;

   modport master (
      output start_i, stop_i, sums_valid_i, pass_i, frame_ready_i,
      input  enable_o, tsel_o, clear_o, frame_o, pass_o, busy_o, overrun_o
   );

   modport slave (
      input  start_i, stop_i, sums_valid_i, pass_i, frame_ready_i,
      output enable_o, tsel_o, clear_o, frame_o, pass_o, busy_o, overrun_o
   );

endinterface

// File: rtl/accum_scheduler_mod_counter.sv
// Modulo-N counter with synchronous restart; wrap_o flags the step that
// returns the count to zero.
module mod_counter
   import accum_scheduler_pkg::*;
#(
   parameter int MODULUS = 4,
   parameter int WIDTH   = 2
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             enable_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] count_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   assign wrap_o = enable_i && (count_o == LAST);

   // A restart wins over a step taken in the same cycle.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_o <= '0;
      end else if (clear_i) begin
         count_o <= '0;
      end else if (enable_i) begin
         count_o <= wrap_o ? '0 : count_o + WIDTH'(1);
      end
   end

endmodule

// File: rtl/accum_scheduler.sv
// Accumulate scheduler: sequences correlator slots and accumulator passes into
// integration frames, with back-pressure hold and end-of-frame stop.
module accum_scheduler
   import accum_scheduler_pkg::*;
#(
   parameter int TRATE = TRATE_DEFAULT,
   parameter int TBITS = TBITS_DEFAULT,
   parameter int LOOPS = LOOPS_DEFAULT,
   parameter int LBITS = LBITS_DEFAULT
) (
   input  logic          clock_i,
   input  logic          reset_ni,
   accum_scheduler_if.slave bus
);

   sched_state_t     state;
   sched_state_t     state_next;
   logic             stop_pending;
   logic             stop_req;
   logic             restart;
   logic             beat_en;
   logic             pass_step;
   logic             frame_end;
   logic             frame_q;
   logic             overrun_q;
   logic [TBITS-1:0] tsel;
   logic [LBITS-1:0] pass_idx;

   assign beat_en   = bus.sums_valid_i && (state == ST_RUN);
   assign pass_step = bus.pass_i && (state == ST_RUN);

   mod_counter #(
      .MODULUS (TRATE),
      .WIDTH   (TBITS)
   ) u_slot_counter (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .enable_i (beat_en),
      .clear_i  (restart),
      .count_o  (tsel),
      .wrap_o   ()
   );

   // The pass counter's wrap is exactly the frame-end condition.
   mod_counter #(
      .MODULUS (LOOPS),
      .WIDTH   (LBITS)
   ) u_pass_counter (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .enable_i (pass_step),
      .clear_i  (restart),
      .count_o  (pass_idx),
      .wrap_o   (frame_end)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A stop raised in the same cycle as a frame decision already counts.
   always_comb begin
      state_next = state;
      restart    = 1'b0;
      stop_req   = stop_pending | bus.stop_i;
      case (state)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_next = ST_RUN;
               restart    = 1'b1;
            end
         end
         ST_RUN: begin
            if (frame_end) begin
               if (!bus.frame_ready_i) begin
                  state_next = ST_HOLD;
               end else if (stop_req) begin
                  state_next = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            if (bus.frame_ready_i) begin
               if (stop_req) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_RUN;
                  restart    = 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stop_pending <= 1'b0;
         frame_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         frame_q <= frame_end;
         if (state == ST_IDLE) begin
            stop_pending <= bus.start_i & bus.stop_i;
         end else if (state_next == ST_IDLE) begin
            stop_pending <= 1'b0;
         end else if (bus.stop_i) begin
            stop_pending <= 1'b1;
         end
         if ((state == ST_IDLE) && bus.start_i) begin
            overrun_q <= 1'b0;
         end else if ((state == ST_HOLD) && bus.sums_valid_i) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign bus.enable_o  = beat_en;
   assign bus.tsel_o    = tsel;
   assign bus.clear_o   = (pass_idx == '0) && (state == ST_RUN);
   assign bus.frame_o   = frame_q;
   assign bus.pass_o    = pass_idx;
   assign bus.busy_o    = (state != ST_IDLE);
   assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_accum_scheduler.sv
// Self-checking bench for accum_scheduler (TRATE=4, LOOPS=3) against a
// cycle-level behavioural model of the frame schedule.
module tb_accum_scheduler;

   localparam int TRATE = 4;
   localparam int TBITS = 2;
   localparam int LOOPS = 3;
   localparam int LBITS = 2;

   typedef enum {M_IDLE, M_RUN, M_HOLD} mode_t;

   logic clock_i  = 1'b0;
   logic reset_ni = 1'b0;

   accum_scheduler_if #(.TBITS(TBITS), .LBITS(LBITS)) bus ();

   accum_scheduler #(
      .TRATE (TRATE),
      .TBITS (TBITS),
      .LOOPS (LOOPS),
      .LBITS (LBITS)
   ) dut (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   always #5 clock_i = ~clock_i;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [8:0] exp_vec;

   mode_t m_mode;
   int    m_slot;
   int    m_pass;
   bit    m_stop;
   bit    m_ovr;
   bit    m_frame;

   function automatic logic [8:0] observed();
      return {bus.enable_o, bus.tsel_o, bus.clear_o, bus.frame_o,
              bus.pass_o, bus.busy_o, bus.overrun_o};
   endfunction

   function automatic string fmt(input logic [8:0] v);
      return $sformatf("en=%b tsel=%0d clr=%b frm=%b pass=%0d busy=%b ovr=%b",
                       v[8], v[7:6], v[5], v[4], v[3:2], v[1], v[0]);
   endfunction

   function automatic logic [8:0] predicted();
      logic             en;
      logic             clr;
      logic             bsy;
      logic [TBITS-1:0] s;
      logic [LBITS-1:0] p;
      en  = bus.sums_valid_i && (m_mode == M_RUN);
      clr = (m_mode == M_RUN) && (m_pass == 0);
      bsy = (m_mode != M_IDLE);
      s   = TBITS'(m_slot);
      p   = LBITS'(m_pass);
      return {en, s, clr, m_frame, p, bsy, m_ovr};
   endfunction

   function automatic void modelReset();
      m_mode  = M_IDLE;
      m_slot  = 0;
      m_pass  = 0;
      m_stop  = 0;
      m_ovr   = 0;
      m_frame = 0;
   endfunction

   // One clock of the schedule: beats advance the slot, passes advance the
   // pass index, and the last pass of a frame decides run / hold / stop.
   function automatic void modelStep();
      bit fe;
      fe = 0;
      case (m_mode)
         M_IDLE: begin
            if (bus.start_i) begin
               m_mode = M_RUN;
               m_slot = 0;
               m_pass = 0;
               m_stop = bus.stop_i;
               m_ovr  = 0;
            end
         end
         M_RUN: begin
            if (bus.stop_i) m_stop = 1;
            if (bus.sums_valid_i) m_slot = (m_slot + 1) % TRATE;
            if (bus.pass_i) begin
               if (m_pass == LOOPS - 1) begin
                  fe     = 1;
                  m_pass = 0;
               end else begin
                  m_pass = m_pass + 1;
               end
            end
            if (fe) begin
               if (!bus.frame_ready_i) begin
                  m_mode = M_HOLD;
               end else if (m_stop) begin
                  m_mode = M_IDLE;
                  m_stop = 0;
               end
            end
         end
         default: begin
            if (bus.sums_valid_i) m_ovr = 1;
            if (bus.stop_i) m_stop = 1;
            if (bus.frame_ready_i) begin
               if (m_stop) begin
                  m_mode = M_IDLE;
                  m_stop = 0;
               end else begin
                  m_mode = M_RUN;
                  m_slot = 0;
                  m_pass = 0;
               end
            end
         end
      endcase
      m_frame = fe;
   endfunction

   task automatic applyStimulus(input bit st, input bit sp, input bit v,
                                input bit p, input bit r);
      @(posedge clock_i);
      if (reset_ni) modelStep();
      #2;
      bus.start_i       = st;
      bus.stop_i        = sp;
      bus.sums_valid_i  = v;
      bus.pass_i        = p;
      bus.frame_ready_i = r;
      #1;
      exp_vec = predicted();
      cyc++;
   endtask

   task automatic doReset();
      #1;
      reset_ni          = 1'b0;
      bus.start_i       = 1'b0;
      bus.stop_i        = 1'b0;
      bus.sums_valid_i  = 1'b0;
      bus.pass_i        = 1'b0;
      bus.frame_ready_i = 1'b0;
      modelReset();
      repeat (2) @(posedge clock_i);
      #2;
      reset_ni = 1'b1;
   endtask

   task automatic test_reset();
      bus.start_i       = 1'b0;
      bus.stop_i        = 1'b0;
      bus.sums_valid_i  = 1'b1;
      bus.pass_i        = 1'b1;
      bus.frame_ready_i = 1'b1;
      reset_ni          = 1'b0;
      modelReset();
      #3;
      if (observed() !== 9'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %s, expected all zero", fmt(observed()));
      end
      checks++;
      doReset();
      // stop_i and pass_i while idle must have no effect
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL idle_ignore cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
      end
   endtask

   task automatic test_continuous();
      int frames;
      frames = 0;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 1; b <= 12; b++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, (b % 4) == 0, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL continuous cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
         if ((bus.tsel_o !== TBITS'((b - 1) % TRATE)) || (bus.clear_o !== (b <= 4))) begin
            errors++;
            $display("[TB] FAIL continuous_beat %0d: got tsel=%0d clr=%b, expected tsel=%0d clr=%b",
                     b, bus.tsel_o, bus.clear_o, (b - 1) % TRATE, (b <= 4));
         end
         checks++;
         if (bus.frame_o === 1'b1) frames++;
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL continuous_tail cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
         if (bus.frame_o === 1'b1) frames++;
      end
      if (frames !== 1) begin
         errors++;
         $display("[TB] FAIL continuous_frames: got %0d pulses, expected 1", frames);
      end
      checks++;
   endtask

   task automatic test_hold_overrun();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int b = 1; b <= 12; b++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, (b % 4) == 0, 1'b0);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL hold_fill cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL hold_wait cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
      end
      if ({bus.enable_o, bus.overrun_o, bus.busy_o} !== 3'b011) begin
         errors++;
         $display("[TB] FAIL hold_flags: got en=%b ovr=%b busy=%b, expected en=0 ovr=1 busy=1",
                  bus.enable_o, bus.overrun_o, bus.busy_o);
      end
      checks++;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 1; b <= 3; b++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL hold_resume cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
         if (b == 1 && (bus.tsel_o !== 2'd0 || bus.pass_o !== 2'd0 || bus.enable_o !== 1'b1)) begin
            errors++;
            $display("[TB] FAIL hold_restart: got tsel=%0d pass=%0d en=%b, expected tsel=0 pass=0 en=1",
                     bus.tsel_o, bus.pass_o, bus.enable_o);
         end
         checks++;
      end
   endtask

   task automatic test_stop();
      int frames;
      frames = 0;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 1; b <= 12; b++) begin
         applyStimulus(1'b0, b == 6, 1'b1, (b % 4) == 0, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL stop_run cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL stop_idle cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
         if (bus.frame_o === 1'b1) frames++;
      end
      if (frames !== 1 || bus.busy_o !== 1'b0 || bus.enable_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stop_end: got frames=%0d busy=%b en=%b, expected frames=1 busy=0 en=0",
                  frames, bus.busy_o, bus.enable_o);
      end
      checks++;
   endtask

   task automatic test_start_stop();
      int frames;
      frames = 0;
      doReset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int b = 1; b <= 16; b++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, (b % 4) == 0, 1'b1);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL start_stop cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
         if (bus.frame_o === 1'b1) frames++;
      end
      if (frames !== 1 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL start_stop_end: got frames=%0d busy=%b, expected frames=1 busy=0", frames, bus.busy_o);
      end
      checks++;
   endtask

   task automatic test_reset_midframe();
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int b = 1; b <= 9; b++) begin
         applyStimulus(1'b0, 1'b1 && b == 2, 1'b1, (b % 4) == 0, 1'b1);
      end
      #2;
      reset_ni = 1'b0;
      #1;
      if (observed() !== 9'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %s, expected all zero", fmt(observed()));
      end
      checks++;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      if (observed() !== exp_vec || bus.pass_o !== 2'd0 || bus.clear_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_restart: got %s, expected %s", fmt(observed()), fmt(exp_vec));
      end
      checks++;
   endtask

   task automatic test_gapped();
      int beats;
      int frame_at;
      beats    = 0;
      frame_at = -1;
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 38; i++) begin
         bit v;
         bit p;
         v = (i % 3) == 0;
         p = v && (((beats + 1) % 4) == 0);
         applyStimulus(1'b0, 1'b0, v, p, 1'b1);
         if (observed() !== exp_vec || bus.tsel_o !== TBITS'(beats % TRATE)) begin
            errors++;
            $display("[TB] FAIL gapped cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
         if (bus.frame_o === 1'b1 && frame_at < 0) frame_at = i;
         if (v) beats++;
      end
      if (frame_at !== 34) begin
         errors++;
         $display("[TB] FAIL gapped_frame: got pulse at step %0d, expected 34", frame_at);
      end
      checks++;
   endtask

   task automatic test_random();
      doReset();
      for (int i = 0; i < 400; i++) begin
         bit v;
         v = ($urandom % 3) != 0;
         applyStimulus(($urandom % 20) == 0, ($urandom % 25) == 0, v,
                       v && (($urandom % 4) == 0), ($urandom % 4) != 0);
         if (observed() !== exp_vec) begin
            errors++;
            $display("[TB] FAIL random cyc %0d: got %s, expected %s", cyc, fmt(observed()), fmt(exp_vec));
         end
         checks++;
      end
   endtask

   initial begin
      $display("[TB] accum_scheduler bench start");
      test_reset();
      test_continuous();
      test_hold_overrun();
      test_stop();
      test_start_stop();
      test_reset_midframe();
      test_gapped();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
